// File: rtl/tff_down_counter.sv
// tff_down_counter: synchronous down counter built from T flip-flops.
// Decrements on each enabled edge, supports parallel load, optional
// auto-reload on underflow, and a combinational borrow-out for cascading.
module tff_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             reload_en,
  output logic [WIDTH-1:0] q,
  output logic             bout,
  output logic             tc_pulse,
  output logic             zero
);

  // Count state (the T flip-flops), reload value and registered flags.
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] rld_q;
  logic             tc_q;
  logic             zero_q;

  // Combinational toggle network.
  logic [WIDTH-1:0] low_zero;   // bit i: all bits below i are zero
  logic [WIDTH-1:0] count_t;    // toggle vector for a plain decrement/wrap
  logic [WIDTH-1:0] t;          // toggle vector actually applied
  logic [WIDTH-1:0] cnt_d;
  logic             cnt_is_zero;
  logic             underflow;

  // Down-count toggle rule via an AND chain of inverted lower bits, plus
  // override toggles for load and reload (T = q ^ next_q).
  always_comb begin
    low_zero    = '1;
    for (int i = 1; i < int'(WIDTH); i++) begin
      low_zero[i] = low_zero[i-1] & ~cnt_q[i-1];
    end
    cnt_is_zero = low_zero[WIDTH-1] & ~cnt_q[WIDTH-1];

    // From zero every bit toggles, which is exactly the wrap to all-ones.
    count_t     = en ? low_zero : '0;
    underflow   = en & ~load & cnt_is_zero;

    t = count_t;
    if (load) begin
      t = cnt_q ^ d;
    end else if (underflow && reload_en) begin
      t = cnt_q ^ rld_q;
    end
    cnt_d = cnt_q ^ t;
  end

  // T flip-flop bank: each bit flips when its T input is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q ^ t;
    end
  end

  // Reload register captures d on every load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rld_q <= '1;
    end else if (load) begin
      rld_q <= d;
    end
  end

  // Registered status: underflow pulse and zero flag aligned with q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tc_q   <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      tc_q   <= underflow;
      zero_q <= (cnt_d == '0);
    end
  end

  // Outputs; bout is same-cycle so a chained stage borrows on this edge.
  always_comb begin
    q        = cnt_q;
    bout     = en & cnt_is_zero;
    tc_pulse = tc_q;
    zero     = zero_q;
  end

endmodule

// File: tb/tb_tff_down_counter.sv
// Self-checking bench for tff_down_counter: directed scenarios plus random
// stimulus against an arithmetic reference model; also a two-stage cascade.
module tb_tff_down_counter;

  logic       clk;
  logic       reset;
  logic       en, load, reload_en;
  logic [3:0] d;
  logic [3:0] q;
  logic       bout, tc_pulse, zero;

  // Cascade: low stage bout drives high stage en.
  logic       cen, cload;
  logic [3:0] cd_lo, cd_hi;
  logic [3:0] lo_q, hi_q;
  logic       lo_bout, hi_bout, lo_tc, hi_tc, lo_zero, hi_zero;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int m_q, m_rld, m_tc;
  int c_val, c_tc;

  tff_down_counter #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .d(d), .reload_en(reload_en),
    .q(q), .bout(bout), .tc_pulse(tc_pulse), .zero(zero)
  );

  tff_down_counter #(.WIDTH(4)) u_lo (
    .clk(clk), .reset(reset), .en(cen), .load(cload), .d(cd_lo), .reload_en(1'b0),
    .q(lo_q), .bout(lo_bout), .tc_pulse(lo_tc), .zero(lo_zero)
  );

  tff_down_counter #(.WIDTH(4)) u_hi (
    .clk(clk), .reset(reset), .en(lo_bout), .load(cload), .d(cd_hi), .reload_en(1'b0),
    .q(hi_q), .bout(hi_bout), .tc_pulse(hi_tc), .zero(hi_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_main();
    check("q", int'(q), m_q);
    check("tc_pulse", int'(tc_pulse), m_tc);
    check("zero", int'(zero), (m_q == 0) ? 1 : 0);
  endtask

  // One clock of the main counter; called at posedge+1.
  task automatic step(input logic l, input logic e, input logic r, input logic [3:0] dv);
    load = l; en = e; reload_en = r; d = dv;
    #1;
    check("bout", int'(bout), (e && m_q == 0) ? 1 : 0);
    @(posedge clk);
    m_tc = 0;
    if (l) begin
      m_q = int'(dv); m_rld = int'(dv);
    end else if (e) begin
      if (m_q != 0) m_q = m_q - 1;
      else begin
        m_q  = r ? m_rld : 15;
        m_tc = 1;
      end
    end
    #1;
    check_main();
  endtask

  // One clock of the 8-bit cascade, modelled as a single 8-bit down counter.
  task automatic cstep(input logic l, input logic e, input logic [7:0] dv);
    cload = l; cen = e; cd_lo = dv[3:0]; cd_hi = dv[7:4];
    #1;
    check("c_bout", int'(lo_bout), (e && (c_val % 16) == 0) ? 1 : 0);
    @(posedge clk);
    c_tc = 0;
    if (l) c_val = int'(dv);
    else if (e) begin
      if ((c_val % 16) == 0) c_tc = 1;
      c_val = (c_val + 255) % 256;
    end
    #1;
    check("c_val", int'({hi_q, lo_q}), c_val);
    check("c_lo_tc", int'(lo_tc), c_tc);
  endtask

  // Async reset asserted between edges; called at posedge+1.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    m_q = 0; m_rld = 15; m_tc = 0; c_val = 0;
    check("rst_q_async", int'(q), 0);
    check("rst_zero_async", int'(zero), 1);
    check("rst_tc_async", int'(tc_pulse), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; en = 0; load = 0; reload_en = 0; d = '0;
    cen = 0; cload = 0; cd_lo = '0; cd_hi = '0;
    m_q = 0; m_rld = 15; m_tc = 0; c_val = 0; c_tc = 0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_main();
    en = 1; #1;
    check("rst_bout", int'(bout), 1);
    en = 0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Reset and wrap: 15 with tc, then 14..0.
    step(0, 1, 0, 4'd0);
    check("wrap_first", int'(q), 15);
    for (int i = 0; i < 15; i++) step(0, 1, 0, 4'd0);

    // Load priority over enable.
    step(1, 0, 0, 4'd9);
    step(1, 1, 0, 4'd5);
    step(0, 1, 0, 4'd0);
    check("load_then_dec", int'(q), 4);

    // Auto-reload timer from 3, then d = 0 continuous pulse.
    step(1, 0, 1, 4'd3);
    for (int i = 0; i < 12; i++) step(0, 1, 1, 4'($urandom_range(0, 15)));
    step(1, 0, 1, 4'd0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 4'd7);

    // Enable gating.
    step(1, 0, 0, 4'd6);
    step(0, 1, 0, 4'd0);
    step(0, 0, 0, 4'd0);
    step(0, 0, 0, 4'd0);
    step(0, 1, 0, 4'd0);
    check("gate_end", int'(q), 4);

    // Cascade: high = 1, low = 0, then one enabled edge -> 0x0F.
    cstep(1, 0, 8'h10);
    cstep(0, 1, 8'h00);
    check("casc_0f", int'({hi_q, lo_q}), 8'h0F);
    for (int i = 0; i < 300; i++) begin
      cstep(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
    end
    cload = 0; cen = 0;

    // Async reset mid-count with q = 7, rld = 3.
    step(1, 0, 0, 4'd3);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 4'd0);
    check("pre_rst_q", int'(q), 7);
    async_reset();
    step(0, 1, 1, 4'd0);
    check("post_rst_reload", int'(q), 15);

    // Random regression on the main counter with occasional async resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) async_reset();
      else step(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                1'($urandom), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
